// File: rtl/flash_read_sequencer.sv
// Block-read sequencer for the SPI flash read controller: one enable window per word,
// captured words are buffered in a small FIFO and handed downstream over valid/ready.
module flash_read_sequencer #(
    parameter int ADDR_WIDTH    = 24,
    parameter int WORD_BITS     = 16,
    parameter int CMD_ADDR_BITS = 32,
    parameter int CS_GAP        = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddress,
    input  logic [15:0]           iWordCount,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oFlashEnable,
    output logic [ADDR_WIDTH-1:0] oFlashAddress,
    input  logic [WORD_BITS-1:0]  iFlashData,
    output logic                  oWordValid,
    output logic [WORD_BITS-1:0]  oWord,
    input  logic                  iWordReady
);

    localparam int XFER_CYCLES = CMD_ADDR_BITS + WORD_BITS;
    localparam int XCNT_W      = $clog2(XFER_CYCLES);
    // CAPTURE and the WAIT_SPACE decision cycle are both gap cycles, so GAP covers the rest.
    localparam int GAP_CYCLES  = (CS_GAP > 2) ? CS_GAP - 2 : 0;
    localparam int GAP_W       = $clog2(CS_GAP + 1);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(WORD_BITS / 8);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        XFER,
        CAPTURE,
        GAP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [XCNT_W-1:0]     xfer_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           remaining;
    logic                  done;

    logic [WORD_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic accept;
    logic push;
    logic pop;
    logic has_space;
    logic xfer_last;
    logic gap_last;
    logic last_word;

    // A request is ignored while the completion pulse of the previous one is still out.
    assign accept    = (state == IDLE) && iStart && !done;
    assign push      = (state == CAPTURE);
    assign pop       = (fifo_count != '0) && iWordReady;
    assign has_space = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign xfer_last = (xfer_cnt == XCNT_W'(XFER_CYCLES - 1));
    assign gap_last  = (int'(gap_cnt) >= GAP_CYCLES - 1);
    assign last_word = (remaining == 16'd1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept && iWordCount != 16'd0) state_next = WAIT_SPACE;
            WAIT_SPACE: if (has_space) state_next = XFER;
            XFER:       if (xfer_last) state_next = CAPTURE;
            CAPTURE: begin
                if (last_word)            state_next = IDLE;
                else if (GAP_CYCLES == 0) state_next = WAIT_SPACE;
                else                      state_next = GAP;
            end
            GAP:        if (gap_last) state_next = WAIT_SPACE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            xfer_cnt   <= '0;
            gap_cnt    <= '0;
            addr       <= '0;
            remaining  <= '0;
            done       <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state    <= state_next;
            xfer_cnt <= (state == XFER) ? xfer_cnt + XCNT_W'(1) : '0;
            gap_cnt  <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            done     <= (accept && iWordCount == 16'd0) || (push && last_word);

            if (accept) begin
                addr      <= iBaseAddress;
                remaining <= iWordCount;
            end else if (push) begin
                addr      <= addr + ADDR_STEP;
                remaining <= remaining - 16'd1;
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= iFlashData;
    end

    assign oBusy         = (state != IDLE) || done;
    assign oDone         = done;
    assign oFlashEnable  = (state == XFER);
    assign oFlashAddress = addr;
    assign oWordValid    = (fifo_count != '0);
    assign oWord         = oWordValid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Randomized bench for flash_read_sequencer: a transaction-level scoreboard predicts window
// addresses and delivered words from each request; the bench also plays the flash controller.
module tb_flash_read_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iStart = 1'b0;
    logic [23:0] iBaseAddress = '0;
    logic [15:0] iWordCount = '0;
    logic        oBusy;
    logic        oDone;
    logic        oFlashEnable;
    logic [23:0] oFlashAddress;
    logic [15:0] iFlashData;
    logic        oWordValid;
    logic [15:0] oWord;
    logic        iWordReady = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    bit          beef_mode = 1'b0;
    logic [15:0] salt = 16'h1234;
    bit          rand_mode = 1'b0;
    logic        ready_force = 1'b1;

    logic [23:0] exp_addrs[$];
    logic [15:0] exp_words[$];
    int          win_starts[$];
    int          win_count = 0;
    int          done_count = 0;
    int          cyc = 0;

    flash_read_sequencer dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iBaseAddress(iBaseAddress),
        .iWordCount(iWordCount), .oBusy(oBusy), .oDone(oDone), .oFlashEnable(oFlashEnable),
        .oFlashAddress(oFlashAddress), .iFlashData(iFlashData), .oWordValid(oWordValid),
        .oWord(oWord), .iWordReady(iWordReady)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] hash_word(input logic [23:0] a, input logic [15:0] s);
        return {a[7:0], a[23:16]} ^ a[15:0] ^ s;
    endfunction

    // Flash device: returns a word derived from the address it was asked for.
    assign iFlashData = beef_mode ? 16'hBEEF : hash_word(oFlashAddress, salt);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        #1;
        iWordReady = rand_mode ? 1'($urandom % 2) : ready_force;
    end

    // Monitor: window shape/address, delivered words, hold under back-pressure.
    logic        prev_en = 1'b0;
    bit          win_abort = 1'b1;
    int          run_len = 0;
    logic [23:0] win_addr = '0;
    bit          stall_prev = 1'b0;
    logic [15:0] stall_word = '0;

    always @(negedge Clock) begin
        if (Reset) win_abort = 1'b1;
        if (oFlashEnable && !prev_en) begin
            win_abort = 1'b0;
            run_len = 1;
            win_addr = oFlashAddress;
            win_count++;
            win_starts.push_back(cyc);
            if (exp_addrs.size() == 0) check_eq("unexpected_window", 1, 0);
            else check_eq("window_addr", oFlashAddress, exp_addrs.pop_front());
        end else if (oFlashEnable) begin
            run_len++;
            if (oFlashAddress !== win_addr) check_eq("addr_stable", oFlashAddress, win_addr);
        end else if (prev_en && !win_abort) begin
            check_eq("window_len", run_len, 48);
        end
        prev_en = oFlashEnable;

        if (!Reset && stall_prev) begin
            check_eq("hold_valid", oWordValid, 1);
            check_eq("hold_word", oWord, stall_word);
        end
        stall_prev = !Reset && oWordValid && !iWordReady;
        stall_word = oWord;

        if (!Reset && oWordValid && iWordReady) begin
            if (exp_words.size() == 0) check_eq("unexpected_word", 1, 0);
            else check_eq("word", oWord, exp_words.pop_front());
        end
        if (oDone) done_count++;
    end

    task automatic start_req(input logic [23:0] base, input logic [15:0] cnt, input bit model);
        @(posedge Clock); #1;
        iStart = 1'b1;
        iBaseAddress = base;
        iWordCount = cnt;
        if (model) begin
            for (int i = 0; i < int'(cnt); i++) begin
                logic [23:0] a;
                a = base + 24'(2 * i);
                exp_addrs.push_back(a);
                exp_words.push_back(beef_mode ? 16'hBEEF : hash_word(a, salt));
            end
        end
        @(posedge Clock); #1;
        iStart = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (!oDone && n < max) begin
            @(posedge Clock); #1;
            n++;
        end
        check_eq(tag, oDone, 1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_words.size() != 0 || oWordValid) && n < 300) begin
            @(posedge Clock); #1;
            n++;
        end
        check_eq(tag, exp_words.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int d0;
        salt = 16'($urandom);

        // Reset held three cycles.
        repeat (3) begin
            @(posedge Clock); #1;
            check_eq("rst_enable", oFlashEnable, 0);
        end
        check_eq("rst_busy", oBusy, 0);
        check_eq("rst_done", oDone, 0);
        check_eq("rst_valid", oWordValid, 0);
        check_eq("rst_addr", oFlashAddress, 0);
        check_eq("rst_word", oWord, 0);
        Reset = 1'b0;

        // Single word returning 0xBEEF.
        beef_mode = 1'b1;
        ready_force = 1'b1;
        w0 = win_count;
        d0 = done_count;
        start_req(24'h000100, 16'd1, 1'b1);
        check_eq("single_busy", oBusy, 1);
        wait_done(200, "single_done");
        check_eq("single_busy_at_done", oBusy, 1);
        @(posedge Clock); #1;
        check_eq("single_busy_after", oBusy, 0);
        check_eq("single_done_pulse", oDone, 0);
        wait_drain("single_drain");
        check_eq("single_windows", win_count - w0, 1);
        check_eq("single_done_count", done_count - d0, 1);
        beef_mode = 1'b0;

        // Burst of three with full-rate spacing.
        w0 = win_count;
        win_starts.delete();
        start_req(24'h000010, 16'd3, 1'b1);
        wait_done(400, "burst_done");
        wait_drain("burst_drain");
        check_eq("burst_windows", win_starts.size(), 3);
        if (win_starts.size() == 3) begin
            check_eq("burst_period0", win_starts[1] - win_starts[0], 50);
            check_eq("burst_period1", win_starts[2] - win_starts[1], 50);
        end

        // Back-pressure: FIFO fills after four words.
        ready_force = 1'b0;
        w0 = win_count;
        start_req(24'($urandom) & 24'hFFFFFE, 16'd6, 1'b1);
        repeat (400) @(posedge Clock);
        #1;
        check_eq("bp_windows_stalled", win_count - w0, 4);
        check_eq("bp_valid", oWordValid, 1);
        check_eq("bp_busy", oBusy, 1);
        check_eq("bp_enable_low", oFlashEnable, 0);
        ready_force = 1'b1;
        wait_done(400, "bp_done");
        wait_drain("bp_drain");
        check_eq("bp_windows_total", win_count - w0, 6);

        // Address wrap.
        w0 = win_count;
        start_req(24'hFFFFFE, 16'd2, 1'b1);
        wait_done(300, "wrap_done");
        wait_drain("wrap_drain");
        check_eq("wrap_windows", win_count - w0, 2);

        // Zero-length request.
        w0 = win_count;
        start_req(24'h000400, 16'd0, 1'b1);
        check_eq("zero_done", oDone, 1);
        @(posedge Clock); #1;
        check_eq("zero_done_pulse", oDone, 0);
        repeat (60) @(posedge Clock);
        #1;
        check_eq("zero_no_window", win_count - w0, 0);

        // Reset in the middle of a window.
        start_req(24'h000200, 16'd3, 1'b1);
        begin
            int n = 0;
            while (!oFlashEnable && n < 20) begin
                @(posedge Clock); #1;
                n++;
            end
            check_eq("mid_enable_rise", oFlashEnable, 1);
        end
        repeat (19) @(posedge Clock);
        #1;
        Reset = 1'b1;
        exp_addrs.delete();
        exp_words.delete();
        @(posedge Clock); #1;
        check_eq("mid_rst_enable", oFlashEnable, 0);
        check_eq("mid_rst_valid", oWordValid, 0);
        check_eq("mid_rst_busy", oBusy, 0);
        check_eq("mid_rst_addr", oFlashAddress, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Request after reset, with a second iStart while busy that must be ignored.
        w0 = win_count;
        start_req(24'h000300, 16'd2, 1'b1);
        repeat (10) @(posedge Clock);
        #1;
        iStart = 1'b1;
        iBaseAddress = 24'h00ABC0;
        iWordCount = 16'd5;
        @(posedge Clock); #1;
        iStart = 1'b0;
        wait_done(300, "ignore_done");
        wait_drain("ignore_drain");
        repeat (60) @(posedge Clock);
        #1;
        check_eq("ignore_windows", win_count - w0, 2);
        check_eq("ignore_idle", oBusy, 0);

        // Randomized requests under random back-pressure.
        rand_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            logic [15:0] cnt;
            cnt = 16'($urandom_range(1, 5));
            w0 = win_count;
            start_req(24'($urandom), cnt, 1'b1);
            wait_done(int'(cnt) * 200 + 100, "rand_done");
            check_eq("rand_windows", win_count - w0, int'(cnt));
        end
        rand_mode = 1'b0;
        ready_force = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        wait_drain("rand_drain");
        check_eq("addrs_consumed", exp_addrs.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/flash_read_sequencer.md
Name: flash_read_sequencer

Overview:
Upstream driver for the SPI flash read controller. Takes a block-read request (base byte address, word count) and issues one controller transaction per 16-bit word: holds the controller enable for the full command+address+data window, then captures the returned word. Captured words are buffered in a small FIFO and handed downstream over a valid/ready interface. Address stepping, inter-transaction chip-select gap, and back-pressure are all handled here.

Parameters:
ADDR_WIDTH, 24, flash byte-address width
WORD_BITS, 16, data bits per transaction
CMD_ADDR_BITS, 32, command+address bits shifted before data (8 cmd + 24 addr)
CS_GAP, 2, minimum cycles enable stays low between transactions (>=1)
FIFO_DEPTH, 4, output buffer depth (power of two, >=2)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
iStart  in  1  one-cycle request pulse; sampled only in IDLE
iBaseAddress  in  ADDR_WIDTH  first byte address, latched on accepted iStart
iWordCount  in  16  number of words to read, latched on accepted iStart
oBusy  out  1  high from accepted iStart until oDone cycle inclusive
oDone  out  1  one-cycle pulse when last word is written into FIFO
oFlashEnable  out  1  to controller iEnable (controller CS = ~enable)
oFlashAddress  out  ADDR_WIDTH  to controller iAddress; stable while oFlashEnable high
iFlashData  in  WORD_BITS  word from controller oData
oWordValid  out  1  FIFO not empty
oWord  out  WORD_BITS  FIFO head word
iWordReady  in  1  downstream accepts head when oWordValid & iWordReady

Behaviour:
- Reset (sync, high): state IDLE; oBusy, oDone, oFlashEnable, oWordValid = 0; oFlashAddress, oWord = 0; FIFO emptied; counters cleared. Reset mid-transfer drops oFlashEnable at that same edge; no partial word pushed.
- States: IDLE, WAIT_SPACE, XFER, CAPTURE, GAP.
- IDLE: on iStart, latch address/count. Count==0 -> next cycle oDone=1 for one cycle, stay IDLE, no flash activity. Else -> WAIT_SPACE, oBusy=1.
- WAIT_SPACE: if FIFO count < FIFO_DEPTH -> XFER (oFlashEnable=1 from next edge); else hold, enable low.
- XFER: oFlashEnable high for exactly CMD_ADDR_BITS+WORD_BITS (48) consecutive cycles; then -> CAPTURE with enable low.
- CAPTURE (1 cycle): iFlashData sampled and pushed into FIFO. Space guaranteed (only pusher; checked in WAIT_SPACE). Decrement remaining; address += WORD_BITS/8 (2), modulo 2^ADDR_WIDTH (0xFFFFFE -> 0x000000). Remaining==0 -> oDone=1 next cycle, -> IDLE. Else -> GAP.
- GAP: enable low for CS_GAP cycles total counting CAPTURE as first gap cycle; then -> WAIT_SPACE.
- Min per-word period: 48 + CS_GAP cycles when FIFO never fills.
- iStart while oBusy: ignored, no effect on latched values.
- FIFO: push and pop same cycle allowed at any occupancy, including full (count unchanged). oWord held stable while oWordValid & ~iWordReady. First-word latency: oWordValid rises the cycle after CAPTURE.
- oDone refers to FIFO fill, not drain; FIFO contents survive return to IDLE and new iStart.

Test Plan:
- Reset idle: hold Reset 3 cycles -> all outputs 0, oFlashEnable never high.
- Single word: iStart, base 0x000100, count 1, iWordReady=1, model returns 0xBEEF -> enable high exactly 48 cycles with address 0x000100, oWord=0xBEEF valid, oDone one pulse, oBusy low after.
- Burst 3, CS_GAP=2: base 0x000010 -> addresses 0x000010/12/14, enable low exactly 2 cycles between windows, words emerge in order.
- Back-pressure: count 6, iWordReady=0 -> exactly 4 transactions then enable stays low; raise iWordReady -> remaining 2 issued, total 6 words in order, no loss/duplication.
- Wrap and zero: base 0xFFFFFE count 2 -> second address 0x000000; count 0 -> oDone next cycle, no enable.
- Reset mid-XFER at cycle 20 of window -> enable low next edge, FIFO empty, iStart afterwards works normally; iStart during busy ignored.
